// File: rtl/riscv_defines.sv
// Shared RISC-V pipeline types: control word, trap request, MEM1 FSM states and dmem trap causes.
package riscv_defines;

  typedef enum logic [1:0] {
    CFLOW_NONE   = 2'd0,
    CFLOW_BRANCH = 2'd1,
    CFLOW_JUMP   = 2'd2
  } cflow_mode_t;

  typedef enum logic [1:0] {
    ALUOP_ALU = 2'd0,
    ALUOP_MUL = 2'd1,
    ALUOP_DIV = 2'd2
  } aluop_t;

  typedef struct packed {
    logic        regwrite;
    logic        memaccess;
    logic        memwrite;
    logic [2:0]  funct3;
    aluop_t      aluop;
    cflow_mode_t cflow_mode;
  } control_signal_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  cause;
    logic [31:0] tval;
    logic [31:0] epc;
  } trap_req_t;

  localparam logic [4:0] CAUSE_LOAD_MISALIGNED     = 5'd4;
  localparam logic [4:0] CAUSE_LOAD_ACCESS_FAULT   = 5'd5;
  localparam logic [4:0] CAUSE_STORE_MISALIGNED    = 5'd6;
  localparam logic [4:0] CAUSE_STORE_ACCESS_FAULT  = 5'd7;

  // funct3[1:0] access width encoding
  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd2;

  typedef enum logic [1:0] {
    MEM1_IDLE = 2'd0,
    MEM1_REQ  = 2'd1,
    MEM1_DONE = 2'd2
  } mem1_state_t;

endpackage

// File: rtl/hazard_interface.sv
// Hazard bus between a pipeline stage (requester) and the central hazard unit (controller).
interface hazard_interface;
  logic       stall_e_req;
  logic       stall_m1_req;
  logic [4:0] rd_m1;
  logic       regwrite_m1;
  logic       memaccess_m1;
  logic       stall_m1;
  logic       flush_m1;

  modport requester (
    output stall_e_req, stall_m1_req, rd_m1, regwrite_m1, memaccess_m1,
    input  stall_m1, flush_m1
  );

  modport controller (
    input  stall_e_req, stall_m1_req, rd_m1, regwrite_m1, memaccess_m1,
    output stall_m1, flush_m1
  );
endinterface

// File: rtl/stage_mem1_align.sv
// mem_align: combinational byte enables, store lane replication and misalignment check.
// Zero latency, no backpressure; shared with MEM2.
module mem_align
  import riscv_defines::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic [31:0] data,
  output logic [3:0]  be,
  output logic [31:0] lane_data,
  output logic        misaligned
);

  always_comb begin
    be         = 4'b1111;
    lane_data  = data;
    misaligned = 1'b0;
    case (size)
      MEM_BYTE: begin
        be        = 4'b0001 << offset;
        lane_data = {4{data[7:0]}};
      end
      MEM_HALF: begin
        be         = 4'b0011 << offset;
        lane_data  = {2{data[15:0]}};
        misaligned = offset[0];
      end
      default: begin
        be         = 4'b1111;
        misaligned = (offset != 2'd0);
      end
    endcase
  end

endmodule

// File: rtl/stage_mem1.sv
// MEM1 stage: registers EX results, raises dmem traps and issues one dmem request per memory op.
// One-cycle capture latency; holds while dmem is not ready or the hazard unit stalls.
module stage_mem1
  import riscv_defines::*;
#(
  parameter logic [31:0] DMEM_SIZE = 32'h0001_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  control_signal_t control_signal_e,
  input  logic [31:0]     pc_e,
  input  logic [31:0]     pcplus4_e,
  input  logic [4:0]      rd_e,
  input  logic            alu_valid,
  input  logic            mul_valid,
  input  logic            div_valid,
  input  logic [31:0]     aluresult_e,
  input  logic [31:0]     mulresult_e,
  input  logic [31:0]     divresult_e,
  input  logic [31:0]     storedata_e,
  input  logic [31:0]     csr_wdata_e,
  input  trap_req_t       trap_req_e,
  output control_signal_t control_signal_m1,
  output logic [4:0]      rd_m1,
  output logic [31:0]     pcplus4_m1,
  output logic [31:0]     result_m1,
  output logic [31:0]     csr_wdata_m1,
  output logic            dmem_req_valid,
  output logic            dmem_we,
  output logic [31:0]     dmem_addr,
  output logic [31:0]     dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_req_ready,
  output trap_req_t       trap_req_m1,
  hazard_interface.requester hazard_bus
);

  mem1_state_t     state_q, state_d;
  control_signal_t ctrl_q;
  logic [4:0]      rd_q;
  logic [31:0]     pcplus4_q, result_q, addr_q, wdata_q, csr_q;
  logic [3:0]      be_q;
  trap_req_t       trap_q, trap_d;

  logic        ex_ready, mem_wait, hold, advance, capture, new_mem;
  logic [31:0] result_d, lane_data_e;
  logic [3:0]  be_e;
  logic        misaligned_e, fault_e;

  mem_align u_align (
    .offset     (aluresult_e[1:0]),
    .size       (control_signal_e.funct3[1:0]),
    .data       (storedata_e),
    .be         (be_e),
    .lane_data  (lane_data_e),
    .misaligned (misaligned_e)
  );

  assign fault_e = (aluresult_e >= DMEM_SIZE);

  always_comb begin
    case (control_signal_e.aluop)
      ALUOP_MUL: ex_ready = mul_valid;
      ALUOP_DIV: ex_ready = div_valid;
      default:   ex_ready = alu_valid;
    endcase
  end

  assign mem_wait = dmem_req_valid && !dmem_req_ready;
  assign hold     = hazard_bus.stall_m1 || mem_wait;
  assign advance  = !hazard_bus.flush_m1 && !hold;
  assign capture  = advance && ex_ready;
  assign new_mem  = control_signal_e.memaccess && !trap_d.valid;

  // Upstream traps take priority; misalignment outranks access fault.
  always_comb begin
    trap_d = '0;
    if (trap_req_e.valid) begin
      trap_d = trap_req_e;
    end else if (control_signal_e.memaccess && (misaligned_e || fault_e)) begin
      trap_d.valid = 1'b1;
      trap_d.tval  = aluresult_e;
      trap_d.epc   = pc_e;
      if (misaligned_e)
        trap_d.cause = control_signal_e.memwrite ? CAUSE_STORE_MISALIGNED : CAUSE_LOAD_MISALIGNED;
      else
        trap_d.cause = control_signal_e.memwrite ? CAUSE_STORE_ACCESS_FAULT : CAUSE_LOAD_ACCESS_FAULT;
    end
  end

  always_comb begin
    result_d = aluresult_e;
    if (control_signal_e.cflow_mode == CFLOW_JUMP)
      result_d = pcplus4_e;
    else if (control_signal_e.aluop == ALUOP_MUL)
      result_d = mulresult_e;
    else if (control_signal_e.aluop == ALUOP_DIV)
      result_d = divresult_e;
    // load data only exists in MEM2
    if (control_signal_e.memaccess && !control_signal_e.memwrite)
      result_d = '0;
  end

  // An un-ready EX unit leaves a bubble so the previous op is not replayed downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q    <= '0;
      rd_q      <= '0;
      pcplus4_q <= '0;
      result_q  <= '0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      csr_q     <= '0;
      trap_q    <= '0;
    end else if (hazard_bus.flush_m1) begin
      ctrl_q <= '0;
      rd_q   <= '0;
      trap_q <= '0;
    end else if (capture) begin
      ctrl_q    <= control_signal_e;
      rd_q      <= rd_e;
      pcplus4_q <= pcplus4_e;
      result_q  <= result_d;
      addr_q    <= aluresult_e;
      be_q      <= be_e;
      wdata_q   <= lane_data_e;
      csr_q     <= csr_wdata_e;
      trap_q    <= trap_d;
    end else if (advance) begin
      ctrl_q <= '0;
      rd_q   <= '0;
      trap_q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= MEM1_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (hazard_bus.flush_m1) begin
      state_d = MEM1_IDLE;
    end else begin
      case (state_q)
        MEM1_IDLE: if (capture && new_mem) state_d = MEM1_REQ;
        MEM1_REQ: begin
          if (dmem_req_valid && dmem_req_ready)
            state_d = (capture && new_mem) ? MEM1_REQ : MEM1_DONE;
        end
        MEM1_DONE: begin
          if (capture && new_mem) state_d = MEM1_REQ;
          else if (advance)       state_d = MEM1_IDLE;
        end
        default: state_d = MEM1_IDLE;
      endcase
    end
  end

  // Reset kills a pending request combinationally so it never appears in the reset cycle.
  always_comb begin
    dmem_req_valid = (state_q == MEM1_REQ) && !trap_q.valid && !rst;
  end

  assign dmem_we    = ctrl_q.memwrite;
  assign dmem_addr  = {addr_q[31:2], 2'b00};
  assign dmem_wdata = wdata_q;
  assign dmem_be    = be_q;

  assign control_signal_m1 = ctrl_q;
  assign rd_m1             = rd_q;
  assign pcplus4_m1        = pcplus4_q;
  assign result_m1         = result_q;
  assign csr_wdata_m1      = csr_q;
  assign trap_req_m1       = trap_q;

  assign hazard_bus.stall_e_req  = !ex_ready;
  assign hazard_bus.stall_m1_req = mem_wait;
  assign hazard_bus.rd_m1        = rd_q;
  assign hazard_bus.regwrite_m1  = ctrl_q.regwrite;
  assign hazard_bus.memaccess_m1 = ctrl_q.memaccess;

endmodule

// File: tb/tb_stage_mem1.sv
// Directed bench for stage_mem1: vector table plus wait-state, flush, reset and MUL-stall sequences.
module tb_stage_mem1;
  import riscv_defines::*;

  logic            clk = 1'b0;
  logic            rst;
  control_signal_t control_signal_e;
  logic [31:0]     pc_e, pcplus4_e, aluresult_e, mulresult_e, divresult_e, storedata_e, csr_wdata_e;
  logic [4:0]      rd_e;
  logic            alu_valid, mul_valid, div_valid;
  trap_req_t       trap_req_e;
  control_signal_t control_signal_m1;
  logic [4:0]      rd_m1;
  logic [31:0]     pcplus4_m1, result_m1, csr_wdata_m1;
  logic            dmem_req_valid, dmem_we, dmem_req_ready;
  logic [31:0]     dmem_addr, dmem_wdata;
  logic [3:0]      dmem_be;
  trap_req_t       trap_req_m1;

  hazard_interface hz ();

  stage_mem1 dut (
    .clk(clk), .rst(rst),
    .control_signal_e(control_signal_e), .pc_e(pc_e), .pcplus4_e(pcplus4_e), .rd_e(rd_e),
    .alu_valid(alu_valid), .mul_valid(mul_valid), .div_valid(div_valid),
    .aluresult_e(aluresult_e), .mulresult_e(mulresult_e), .divresult_e(divresult_e),
    .storedata_e(storedata_e), .csr_wdata_e(csr_wdata_e), .trap_req_e(trap_req_e),
    .control_signal_m1(control_signal_m1), .rd_m1(rd_m1), .pcplus4_m1(pcplus4_m1),
    .result_m1(result_m1), .csr_wdata_m1(csr_wdata_m1),
    .dmem_req_valid(dmem_req_valid), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_req_ready(dmem_req_ready),
    .trap_req_m1(trap_req_m1), .hazard_bus(hz)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic control_signal_t mk_ctrl(input logic rw, input logic ma, input logic mw,
                                               input logic [2:0] f3, input aluop_t op,
                                               input cflow_mode_t cf);
    control_signal_t c;
    c.regwrite = rw; c.memaccess = ma; c.memwrite = mw;
    c.funct3 = f3; c.aluop = op; c.cflow_mode = cf;
    return c;
  endfunction

  task automatic drive(input control_signal_t c, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] mul, input logic [31:0] dv, input logic [31:0] pc4,
                       input logic [31:0] sd, input trap_req_t te);
    control_signal_e = c; rd_e = rd; aluresult_e = alu; mulresult_e = mul;
    divresult_e = dv; pcplus4_e = pc4; pc_e = pc4 - 32'd4; storedata_e = sd; trap_req_e = te;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    control_signal_t ctrl;
    logic [4:0]  rd;
    logic [31:0] alu, mul, dv, pc4, sd;
    trap_req_t   te;
    logic        exp_req;
    logic [31:0] exp_result, exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    logic        exp_tv;
    logic [4:0]  exp_cause;
    logic [31:0] exp_tval;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vec [NVEC];

  control_signal_t c_nop, c_alu, c_jal, c_mul, c_div, c_sw, c_sb, c_sh, c_lw, c_lb, c_lh;
  trap_req_t te_none, te_up;
  int stall_cnt;

  initial begin
    c_nop = '0;
    c_alu = mk_ctrl(1'b1, 1'b0, 1'b0, 3'b000, ALUOP_ALU, CFLOW_NONE);
    c_jal = mk_ctrl(1'b1, 1'b0, 1'b0, 3'b000, ALUOP_ALU, CFLOW_JUMP);
    c_mul = mk_ctrl(1'b1, 1'b0, 1'b0, 3'b000, ALUOP_MUL, CFLOW_NONE);
    c_div = mk_ctrl(1'b1, 1'b0, 1'b0, 3'b100, ALUOP_DIV, CFLOW_NONE);
    c_sw  = mk_ctrl(1'b0, 1'b1, 1'b1, 3'b010, ALUOP_ALU, CFLOW_NONE);
    c_sb  = mk_ctrl(1'b0, 1'b1, 1'b1, 3'b000, ALUOP_ALU, CFLOW_NONE);
    c_sh  = mk_ctrl(1'b0, 1'b1, 1'b1, 3'b001, ALUOP_ALU, CFLOW_NONE);
    c_lw  = mk_ctrl(1'b1, 1'b1, 1'b0, 3'b010, ALUOP_ALU, CFLOW_NONE);
    c_lb  = mk_ctrl(1'b1, 1'b1, 1'b0, 3'b000, ALUOP_ALU, CFLOW_NONE);
    c_lh  = mk_ctrl(1'b1, 1'b1, 1'b0, 3'b001, ALUOP_ALU, CFLOW_NONE);
    te_none = '0;
    te_up = '0;
    te_up.valid = 1'b1; te_up.cause = 5'd2; te_up.tval = 32'h0000_0BAD; te_up.epc = 32'h80;

    // ctrl rd alu mul div pc4 sd te | req result addr wdata be | tv cause tval
    vec[0]  = '{c_alu, 5'd1, 32'h1234_5678, 32'h0, 32'h0, 32'h14, 32'h0, te_none, 1'b0, 32'h1234_5678, 32'h0, 32'h0, 4'h0, 1'b0, 5'd0, 32'h0};
    vec[1]  = '{c_jal, 5'd2, 32'h0000_0999, 32'h0, 32'h0, 32'h104, 32'h0, te_none, 1'b0, 32'h0000_0104, 32'h0, 32'h0, 4'h0, 1'b0, 5'd0, 32'h0};
    vec[2]  = '{c_mul, 5'd3, 32'h5, 32'hCAFE_F00D, 32'h0, 32'h18, 32'h0, te_none, 1'b0, 32'hCAFE_F00D, 32'h0, 32'h0, 4'h0, 1'b0, 5'd0, 32'h0};
    vec[3]  = '{c_div, 5'd4, 32'h6, 32'h1, 32'h7, 32'h1C, 32'h0, te_none, 1'b0, 32'h7, 32'h0, 32'h0, 4'h0, 1'b0, 5'd0, 32'h0};
    vec[4]  = '{c_sw, 5'd0, 32'h104, 32'h0, 32'h0, 32'h20, 32'hDEAD_BEEF, te_none, 1'b1, 32'h104, 32'h104, 32'hDEAD_BEEF, 4'hF, 1'b0, 5'd0, 32'h0};
    vec[5]  = '{c_sb, 5'd0, 32'h103, 32'h0, 32'h0, 32'h24, 32'h0000_00A5, te_none, 1'b1, 32'h103, 32'h100, 32'hA5A5_A5A5, 4'h8, 1'b0, 5'd0, 32'h0};
    vec[6]  = '{c_sh, 5'd0, 32'h102, 32'h0, 32'h0, 32'h28, 32'h1234_BEEF, te_none, 1'b1, 32'h102, 32'h100, 32'hBEEF_BEEF, 4'hC, 1'b0, 5'd0, 32'h0};
    vec[7]  = '{c_sh, 5'd0, 32'h101, 32'h0, 32'h0, 32'h2C, 32'h0000_1111, te_none, 1'b0, 32'h101, 32'h0, 32'h0, 4'h0, 1'b1, 5'd6, 32'h101};
    vec[8]  = '{c_lw, 5'd5, 32'h0001_0000, 32'h0, 32'h0, 32'h30, 32'h0, te_none, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b1, 5'd5, 32'h0001_0000};
    vec[9]  = '{c_lw, 5'd6, 32'h0001_FFFE, 32'h0, 32'h0, 32'h34, 32'h0, te_none, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b1, 5'd4, 32'h0001_FFFE};
    vec[10] = '{c_sw, 5'd0, 32'h8, 32'h0, 32'h0, 32'h38, 32'h5555_5555, te_up, 1'b0, 32'h8, 32'h0, 32'h0, 4'h0, 1'b1, 5'd2, 32'h0000_0BAD};
    vec[11] = '{c_lb, 5'd7, 32'h203, 32'h0, 32'h0, 32'h3C, 32'h0, te_none, 1'b1, 32'h0, 32'h200, 32'h0, 4'h8, 1'b0, 5'd0, 32'h0};
    vec[12] = '{c_sw, 5'd0, 32'h0000_FFFC, 32'h0, 32'h0, 32'h40, 32'h0BAD_F00D, te_none, 1'b1, 32'h0000_FFFC, 32'h0000_FFFC, 32'h0BAD_F00D, 4'hF, 1'b0, 5'd0, 32'h0};
    vec[13] = '{c_lh, 5'd8, 32'h0000_FFFE, 32'h0, 32'h0, 32'h44, 32'h0, te_none, 1'b1, 32'h0, 32'h0000_FFFC, 32'h0, 4'hC, 1'b0, 5'd0, 32'h0};

    rst = 1'b1;
    alu_valid = 1'b1; mul_valid = 1'b1; div_valid = 1'b1;
    dmem_req_ready = 1'b1; csr_wdata_e = '0;
    hz.stall_m1 = 1'b0; hz.flush_m1 = 1'b0;
    drive(c_nop, 5'd0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h0, te_none);

    tick(); tick();
    chk("rst result", result_m1, 32'h0);
    chk("rst rd", {27'h0, rd_m1}, 32'h0);
    chk("rst ctrl", {22'h0, control_signal_m1}, 32'h0);
    chk("rst trap valid", {31'h0, trap_req_m1.valid}, 32'h0);
    chk("rst req valid", {31'h0, dmem_req_valid}, 32'h0);
    chk("rst addr", dmem_addr, 32'h0);
    chk("rst state", 32'(dut.state_q), 32'(MEM1_IDLE));
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      drive(vec[i].ctrl, vec[i].rd, vec[i].alu, vec[i].mul, vec[i].dv, vec[i].pc4, vec[i].sd, vec[i].te);
      tick();
      chk($sformatf("v%0d result", i), result_m1, vec[i].exp_result);
      chk($sformatf("v%0d rd", i), {27'h0, rd_m1}, {27'h0, vec[i].rd});
      chk($sformatf("v%0d req_valid", i), {31'h0, dmem_req_valid}, {31'h0, vec[i].exp_req});
      chk($sformatf("v%0d trap valid", i), {31'h0, trap_req_m1.valid}, {31'h0, vec[i].exp_tv});
      if (vec[i].exp_req) begin
        chk($sformatf("v%0d addr", i), dmem_addr, vec[i].exp_addr);
        chk($sformatf("v%0d be", i), {28'h0, dmem_be}, {28'h0, vec[i].exp_be});
        chk($sformatf("v%0d wdata", i), dmem_wdata, vec[i].exp_wdata);
        chk($sformatf("v%0d we", i), {31'h0, dmem_we}, {31'h0, vec[i].ctrl.memwrite});
        chk($sformatf("v%0d stall_m1", i), {31'h0, hz.stall_m1_req}, 32'h0);
      end
      if (vec[i].exp_tv) begin
        chk($sformatf("v%0d cause", i), {27'h0, trap_req_m1.cause}, {27'h0, vec[i].exp_cause});
        chk($sformatf("v%0d tval", i), trap_req_m1.tval, vec[i].exp_tval);
      end
    end
    drive(c_nop, 5'd0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h0, te_none);
    tick();
    chk("drain req_valid", {31'h0, dmem_req_valid}, 32'h0);

    // MUL waits two cycles for mul_valid; bubbles go down while EX is stalled
    drive(c_mul, 5'd10, 32'h1, 32'h0000_0E11, 32'h0, 32'h50, 32'h0, te_none);
    csr_wdata_e = 32'h55;
    stall_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      mul_valid = (c >= 2);
      #1;
      if (!hz.stall_e_req) break;
      stall_cnt++;
      tick();
      chk("mul bubble rd", {27'h0, rd_m1}, 32'h0);
    end
    tick();
    chk("mul stall cycles", stall_cnt, 32'd2);
    chk("mul result", result_m1, 32'h0000_0E11);
    chk("mul rd", {27'h0, rd_m1}, 32'd10);
    chk("mul csr", csr_wdata_m1, 32'h55);

    // lw with three wait states
    dmem_req_ready = 1'b0;
    drive(c_lw, 5'd9, 32'h200, 32'h0, 32'h0, 32'h54, 32'h0, te_none);
    tick();
    drive(c_alu, 5'd3, 32'h77, 32'h0, 32'h0, 32'h58, 32'h0, te_none);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("lw wait%0d valid", k), {31'h0, dmem_req_valid}, 32'h1);
      chk($sformatf("lw wait%0d addr", k), dmem_addr, 32'h200);
      chk($sformatf("lw wait%0d stall", k), {31'h0, hz.stall_m1_req}, 32'h1);
      chk($sformatf("lw wait%0d rd", k), {27'h0, rd_m1}, 32'd9);
      if (k < 2) tick();
    end
    tick();
    dmem_req_ready = 1'b1;
    #1;
    chk("lw 4th valid", {31'h0, dmem_req_valid}, 32'h1);
    chk("lw 4th stall", {31'h0, hz.stall_m1_req}, 32'h0);
    tick();
    chk("lw done valid", {31'h0, dmem_req_valid}, 32'h0);
    chk("lw advance rd", {27'h0, rd_m1}, 32'd3);
    chk("lw advance result", result_m1, 32'h77);

    // flush while a request is waiting
    dmem_req_ready = 1'b0;
    drive(c_lw, 5'd12, 32'h300, 32'h0, 32'h0, 32'h60, 32'h0, te_none);
    tick();
    chk("flush pre valid", {31'h0, dmem_req_valid}, 32'h1);
    hz.flush_m1 = 1'b1;
    drive(c_nop, 5'd0, 32'h0, 32'h0, 32'h0, 32'h64, 32'h0, te_none);
    tick();
    hz.flush_m1 = 1'b0;
    chk("flush valid", {31'h0, dmem_req_valid}, 32'h0);
    chk("flush state", 32'(dut.state_q), 32'(MEM1_IDLE));
    chk("flush rd", {27'h0, rd_m1}, 32'h0);
    chk("flush ctrl", {22'h0, control_signal_m1}, 32'h0);
    tick();
    chk("flush no reissue", {31'h0, dmem_req_valid}, 32'h0);

    // reset while a store is waiting
    drive(c_sw, 5'd0, 32'h400, 32'h0, 32'h0, 32'h68, 32'h1234_5678, te_none);
    csr_wdata_e = 32'h99;
    tick();
    chk("rst pre valid", {31'h0, dmem_req_valid}, 32'h1);
    rst = 1'b1;
    drive(c_nop, 5'd0, 32'h0, 32'h0, 32'h0, 32'h6C, 32'h0, te_none);
    #1;
    chk("rst same-cycle valid", {31'h0, dmem_req_valid}, 32'h0);
    tick();
    chk("rst2 addr", dmem_addr, 32'h0);
    chk("rst2 wdata", dmem_wdata, 32'h0);
    chk("rst2 be", {28'h0, dmem_be}, 32'h0);
    chk("rst2 we", {31'h0, dmem_we}, 32'h0);
    chk("rst2 csr", csr_wdata_m1, 32'h0);
    chk("rst2 ctrl", {22'h0, control_signal_m1}, 32'h0);
    chk("rst2 state", 32'(dut.state_q), 32'(MEM1_IDLE));
    rst = 1'b0;
    dmem_req_ready = 1'b1;
    tick();
    chk("rst release valid", {31'h0, dmem_req_valid}, 32'h0);
    tick();
    chk("rst release valid2", {31'h0, dmem_req_valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stage_mem1.md
STAGE_MEM1 -- requirements
Module: stage_mem1

Interface
REQ-001 SHALL provide parameter DMEM_SIZE, default 32'h0001_0000: data-memory size in bytes; any access address >= DMEM_SIZE is an access fault.
REQ-002 SHALL provide port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL provide inputs control_signal_e (control_signal_t), pc_e, pcplus4_e (32), rd_e (5): instruction context from EX.
REQ-005 SHALL provide inputs alu_valid, mul_valid, div_valid (1 each) and aluresult_e, mulresult_e, divresult_e (32 each): EX unit results.
REQ-006 SHALL provide inputs storedata_e and csr_wdata_e (32 each) and trap_req_e (trap_req_t).
REQ-007 SHALL provide outputs control_signal_m1, rd_m1, pcplus4_m1, result_m1 (32) and csr_wdata_m1 (32).
REQ-008 SHALL provide dmem outputs dmem_req_valid (1), dmem_we (1), dmem_addr (32), dmem_wdata (32), dmem_be (4), and input dmem_req_ready (1).
REQ-009 SHALL provide output trap_req_m1 (trap_req_t) and port hazard_bus (hazard_interface.requester).

Function
REQ-010 Capture: when neither flush_m1 nor stall_m1 is asserted, all EX inputs SHALL be registered; on stall_m1 all registers SHALL hold.
REQ-011 Flush: flush_m1 SHALL clear control_signal_m1, rd_m1 and trap_req_m1 to zero and return the FSM to IDLE, dropping any request that was not yet accepted.
REQ-012 Result select, with the chosen value registered into result_m1:
- jal/jalr (cflow_mode jump): pcplus4_e
- aluop MUL: mulresult_e
- aluop DIV: divresult_e
- otherwise: aluresult_e
REQ-013 Readiness: EX SHALL NOT be captured while the selected unit's valid flag is low.
- The stage SHALL request stall_e via hazard_bus while this condition holds.
REQ-014 The address for memaccess SHALL be the registered aluresult; dmem_addr SHALL be that address with bits [1:0] forced to 0.
REQ-015 Byte enables by funct3 width at offset o = addr[1:0]:
- byte: 4'b0001<<o
- half: 4'b0011<<o
- word: 4'b1111
REQ-016 dmem_wdata SHALL hold the store data replicated across byte lanes (byte x4, half x2).
REQ-017 Misalignment: half with o[0]=1, or word with o!=0, SHALL raise trap cause LOAD/STORE_MISALIGNED with tval = byte address.
REQ-018 Access fault: an address >= DMEM_SIZE SHALL raise cause LOAD/STORE_ACCESS_FAULT with tval = byte address.
REQ-019 Trap priority: a valid trap_req_e SHALL win over any locally raised trap.
- Any valid trap_req_m1 SHALL suppress dmem_req_valid, so no store is ever issued for a trapping instruction.
REQ-020 FSM states IDLE, REQ, DONE:
- IDLE->REQ on capture of a non-trapping memaccess.
- REQ->DONE on dmem_req_valid && dmem_req_ready.
- DONE->REQ on the next memaccess capture.
- DONE->IDLE on the next non-memaccess capture.
- Flush forces IDLE in every state.
REQ-021 dmem_req_valid SHALL be 1 only in REQ, and address, we, be and wdata SHALL stay stable while valid && !ready.
REQ-022 While in REQ and not yet ready, the stage SHALL request stall_m1 through hazard_bus; zero-wait (ready already high) SHALL complete in one cycle.
REQ-023 Back-to-back memory operations SHALL issue one request per cycle when ready is continuously high.
REQ-024 Hazard packet SHALL export rd_m1, regwrite_m1 and memaccess_m1 for forwarding.
- result_m1 SHALL carry only non-load results; a load's result is produced in MEM2.

Reset
REQ-025 On rst all outputs and registers SHALL be zero, FSM=IDLE, dmem_req_valid=0, trap_req_m1.valid=0.
REQ-026 rst asserted mid-request (state REQ) SHALL drop the request in the same cycle, and no request SHALL be re-issued after release.

Structure
REQ-027 The FSM state enum and the dmem trap cause codes SHALL live in riscv_defines, reusing CAUSE_* naming.
REQ-028 A single sub-module, mem_align (byte enable, lane replication, misalignment check), is natural and SHALL be reused by MEM2 for load extraction.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- sw addr 0x104, data 0xDEADBEEF, ready=1 -> one-cycle request, be=1111, addr=0x104, no stall.
- sb addr 0x103, data 0x000000A5 -> be=1000, wdata=0xA5A5A5A5.
- sh addr 0x101 -> trap_req_m1 STORE_MISALIGNED, tval=0x101, dmem_req_valid never 1.
- lw addr 0x200 with ready low 3 cycles -> valid held 4 cycles with stable addr and stall_m1 asserted; advance on the 4th.
- Flush in REQ with ready low -> valid drops next cycle, FSM=IDLE; rst in REQ -> all outputs 0.
- MUL with mul_valid low 2 cycles -> stall_e asserted 2 cycles, then result_m1 = mulresult_e.
